// File: rtl/htu_way_alloc_pkg.sv
// Shared types and constants for the HTU way allocator.
// Latency: none (declarations only).
// Backpressure: n/a.
//
// Contents: configuration struct, allocator FSM state enum, counter widths,
// and a helper that sizes a way index so that a one-way cache still gets a
// 1-bit index.
package htu_way_alloc_pkg;

  typedef struct packed {
    int unsigned wayNum;
    int unsigned setWidth;
  } mpc_cfg_t;

  localparam mpc_cfg_t MPC_CFG_DEFAULT = '{wayNum: 32'd4, setWidth: 32'd8};

  typedef enum logic [1:0] {
    HTU_ST_IDLE  = 2'd0,
    HTU_ST_WAIT  = 2'd1,
    HTU_ST_EVAL  = 2'd2,
    HTU_ST_GRANT = 2'd3
  } htu_alloc_state_e;

  localparam int unsigned HTU_STALL_CNT_W = 8;
  localparam int unsigned HTU_REF_CNT_W   = 3;

  function automatic int unsigned way_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/htu_way_alloc_if.sv
// Bundle of all allocator-facing signals: request, grant, counter lookup/increment.
// Latency: none (wires only).
// Backpressure: request uses valid/ready; grant uses valid/ready.
//
// Modports: slave = the allocator itself, master = its environment
// (requester, grant consumer and reference counter together).
interface htu_way_alloc_if
  import htu_way_alloc_pkg::*;
#(
  parameter mpc_cfg_t Cfg = MPC_CFG_DEFAULT
) ();

  localparam int unsigned WAY_NUM = Cfg.wayNum;
  localparam int unsigned SET_W   = Cfg.setWidth;
  localparam int unsigned WAY_W   = way_idx_w(Cfg.wayNum);

  logic                                   alloc_req_valid;
  logic [SET_W-1:0]                       alloc_req_set;
  logic                                   alloc_req_ready;
  logic                                   alloc_flush;
  logic [WAY_NUM-1:0]                     way_pin_mask;
  logic [SET_W-1:0]                       ref_cnt_set;
  logic [WAY_NUM-1:0][HTU_REF_CNT_W-1:0]  ref_cnt_rsp;
  logic                                   alloc_rsp_valid;
  logic [SET_W-1:0]                       alloc_rsp_set;
  logic [WAY_W-1:0]                       alloc_rsp_way;
  logic                                   alloc_rsp_ready;
  logic                                   ref_cnt_access_valid;
  logic [SET_W-1:0]                       ref_cnt_access_set;
  logic [WAY_W-1:0]                       ref_cnt_access_way;
  logic [HTU_STALL_CNT_W-1:0]             alloc_stall_cnt;

  modport slave (
    input  alloc_req_valid, alloc_req_set, alloc_flush, way_pin_mask,
           ref_cnt_rsp, alloc_rsp_ready,
    output alloc_req_ready, ref_cnt_set, alloc_rsp_valid, alloc_rsp_set,
           alloc_rsp_way, ref_cnt_access_valid, ref_cnt_access_set,
           ref_cnt_access_way, alloc_stall_cnt
  );

  modport master (
    output alloc_req_valid, alloc_req_set, alloc_flush, way_pin_mask,
           ref_cnt_rsp, alloc_rsp_ready,
    input  alloc_req_ready, ref_cnt_set, alloc_rsp_valid, alloc_rsp_set,
           alloc_rsp_way, ref_cnt_access_valid, ref_cnt_access_set,
           ref_cnt_access_way, alloc_stall_cnt
  );

endinterface

// File: rtl/htu_way_alloc_rr_pick.sv
// Round-robin first-one picker: first set bit of req_i at or after ptr_i, wrapping.
// Latency: combinational.
// Backpressure: none.
//
// Ports: req_i (N request bits), ptr_i (start index, must be < N),
// found_o (any request set), idx_o (chosen index, 0 when none).
// N need not be a power of two, so the wrap is an explicit subtract.
module htu_rr_pick #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 2
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic         found_o,
  output logic [W-1:0] idx_o
);

  logic [W:0] pos;

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    pos     = '0;
    for (int k = 0; k < int'(N); k++) begin
      // One extra bit so ptr + k cannot overflow before the modulo wrap.
      pos = {1'b0, ptr_i} + (W + 1)'(k);
      if (pos >= (W + 1)'(N)) begin
        pos = pos - (W + 1)'(N);
      end
      if (!found_o && req_i[pos[W-1:0]]) begin
        found_o = 1'b1;
        idx_o   = pos[W-1:0];
      end
    end
  end

endmodule

// File: rtl/ns_gnrl_dfflr.sv
// Generic load-enabled flop with synchronous active-low reset to zero.
// Latency: 1 cycle from d_i to q_o when lden_i is high.
// Backpressure: none; holds value while lden_i is low.
//
// Ports: clk_i, rst_ni (sync, active-low), lden_i (load enable), d_i, q_o.
module ns_gnrl_dfflr #(
  parameter int unsigned DW = 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          lden_i,
  input  logic [DW-1:0] d_i,
  output logic [DW-1:0] q_o
);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      q_o <= '0;
    end else if (lden_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/htu_way_alloc.sv
// HTU way allocator: reads per-way ref counts for a set, grants a free unpinned way round-robin.
// Latency: request accepted at T -> grant valid at T+3 earliest; one allocation per 4 cycles max.
// Backpressure: req_ready only in IDLE; grant held stable until rsp_ready; no-candidate EVAL stalls.
//
// Ports: clk, rst_n (sync, active-low), alloc_if (slave modport) carrying the
// request, flush, pin mask, counter lookup (ref_cnt_set/rsp), grant
// (alloc_rsp_*), counter increment (ref_cnt_access_*) and the stall counter.
module htu_way_alloc
  import htu_way_alloc_pkg::*;
#(
  parameter mpc_cfg_t Cfg = MPC_CFG_DEFAULT
) (
  input  logic           clk,
  input  logic           rst_n,
  htu_way_alloc_if.slave alloc_if
);

  localparam int unsigned WAY_NUM = Cfg.wayNum;
  localparam int unsigned SET_W   = Cfg.setWidth;
  localparam int unsigned WAY_W   = way_idx_w(Cfg.wayNum);
  localparam int unsigned CNT_W   = HTU_STALL_CNT_W;

  typedef logic [SET_W-1:0] setWidth_t;
  typedef logic [WAY_W-1:0] wayIndexWidth_t;

  logic [1:0]        state_raw_q;
  htu_alloc_state_e  state_q;
  htu_alloc_state_e  state_d;

  setWidth_t         set_q;
  logic              set_ld;

  wayIndexWidth_t    rr_ptr_q;
  wayIndexWidth_t    rr_ptr_d;
  logic              rr_ptr_ld;

  logic [CNT_W-1:0]  stall_q;
  logic [CNT_W-1:0]  stall_d;
  logic              stall_ld;

  setWidth_t         rsp_set_q;
  wayIndexWidth_t    rsp_way_q;
  logic              rsp_ld;

  logic [WAY_NUM-1:0] cand;
  logic              pick_found;
  wayIndexWidth_t    pick_idx;
  logic              grant_hs;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  ns_gnrl_dfflr #(.DW(2)) u_state_q (
    .clk_i (clk), .rst_ni (rst_n), .lden_i (1'b1),
    .d_i   (state_d), .q_o (state_raw_q)
  );
  assign state_q = htu_alloc_state_e'(state_raw_q);

  ns_gnrl_dfflr #(.DW(SET_W)) u_set_q (
    .clk_i (clk), .rst_ni (rst_n), .lden_i (set_ld),
    .d_i   (alloc_if.alloc_req_set), .q_o (set_q)
  );

  ns_gnrl_dfflr #(.DW(WAY_W)) u_rr_ptr_q (
    .clk_i (clk), .rst_ni (rst_n), .lden_i (rr_ptr_ld),
    .d_i   (rr_ptr_d), .q_o (rr_ptr_q)
  );

  ns_gnrl_dfflr #(.DW(CNT_W)) u_stall_q (
    .clk_i (clk), .rst_ni (rst_n), .lden_i (stall_ld),
    .d_i   (stall_d), .q_o (stall_q)
  );

  ns_gnrl_dfflr #(.DW(SET_W)) u_rsp_set_q (
    .clk_i (clk), .rst_ni (rst_n), .lden_i (rsp_ld),
    .d_i   (set_q), .q_o (rsp_set_q)
  );

  ns_gnrl_dfflr #(.DW(WAY_W)) u_rsp_way_q (
    .clk_i (clk), .rst_ni (rst_n), .lden_i (rsp_ld),
    .d_i   (pick_idx), .q_o (rsp_way_q)
  );

  // ---------------------------------------------------------------------------
  // Victim selection: free (count 0) and not pinned; pin mask is used live.
  // ---------------------------------------------------------------------------
  always_comb begin
    cand = '0;
    for (int i = 0; i < int'(WAY_NUM); i++) begin
      cand[i] = (alloc_if.ref_cnt_rsp[i] == '0) && !alloc_if.way_pin_mask[i];
    end
  end

  htu_rr_pick #(.N(WAY_NUM), .W(WAY_W)) u_rr_pick (
    .req_i   (cand),
    .ptr_i   (rr_ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  assign grant_hs = (state_q == HTU_ST_GRANT) && alloc_if.alloc_rsp_ready;

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    set_ld    = 1'b0;
    rr_ptr_ld = 1'b0;
    stall_ld  = 1'b0;
    rsp_ld    = 1'b0;
    // Pointer moves to the way after the one just granted.
    rr_ptr_d  = (rsp_way_q == WAY_W'(WAY_NUM - 1)) ? '0 : rsp_way_q + 1'b1;
    stall_d   = stall_q + 1'b1;

    unique case (state_q)
      HTU_ST_IDLE: begin
        if (alloc_if.alloc_req_valid) begin
          set_ld  = 1'b1;
          state_d = HTU_ST_WAIT;
        end
      end
      HTU_ST_WAIT: begin
        state_d = alloc_if.alloc_flush ? HTU_ST_IDLE : HTU_ST_EVAL;
      end
      HTU_ST_EVAL: begin
        // Every candidate-less EVAL cycle counts, including one that is flushed.
        if (!pick_found && (stall_q != '1)) begin
          stall_ld = 1'b1;
        end
        if (alloc_if.alloc_flush) begin
          state_d = HTU_ST_IDLE;
        end else if (pick_found) begin
          rsp_ld  = 1'b1;
          state_d = HTU_ST_GRANT;
        end
      end
      HTU_ST_GRANT: begin
        // Flush is deliberately ignored here: a presented grant always completes.
        if (alloc_if.alloc_rsp_ready) begin
          rr_ptr_ld = 1'b1;
          state_d   = HTU_ST_IDLE;
        end
      end
      default: begin
        state_d = HTU_ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign alloc_if.alloc_req_ready      = (state_q == HTU_ST_IDLE);
  assign alloc_if.ref_cnt_set          = set_q;
  assign alloc_if.alloc_rsp_valid      = (state_q == HTU_ST_GRANT);
  assign alloc_if.alloc_rsp_set        = rsp_set_q;
  assign alloc_if.alloc_rsp_way        = rsp_way_q;
  assign alloc_if.ref_cnt_access_valid = grant_hs;
  assign alloc_if.ref_cnt_access_set   = rsp_set_q;
  assign alloc_if.ref_cnt_access_way   = rsp_way_q;
  assign alloc_if.alloc_stall_cnt      = stall_q;

endmodule

// File: tb/tb_htu_way_alloc.sv
// Directed bench for htu_way_alloc with a grant scoreboard and a registered counter model.
// Latency: n/a.
// Backpressure: exercises grant backpressure, flush and reset.
module tb_htu_way_alloc;
  import htu_way_alloc_pkg::*;

  localparam mpc_cfg_t CFG = '{wayNum: 32'd4, setWidth: 32'd8};

  typedef struct packed {
    logic [7:0] set;
    logic [1:0] way;
  } grant_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  htu_way_alloc_if #(.Cfg(CFG)) bus ();

  htu_way_alloc #(.Cfg(CFG)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .alloc_if (bus.slave)
  );

  int checks   = 0;
  int failures = 0;
  int pulse_cnt = 0;
  int p0;
  grant_t exp_q[$];

  // Current per-way counts for the looked-up set; the counter returns them one cycle later.
  logic [3:0][2:0] cnt_tb;
  always @(posedge clk) bus.ref_cnt_rsp <= cnt_tb;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every increment pulse must match the oldest outstanding grant.
  always @(negedge clk) begin : mon
    grant_t g;
    if (bus.ref_cnt_access_valid === 1'b1) begin
      pulse_cnt++;
      check("pulse_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        g = exp_q.pop_front();
        check("access_set", bus.ref_cnt_access_set, g.set);
        check("access_way", bus.ref_cnt_access_way, g.way);
        check("rsp_set_at_hs", bus.alloc_rsp_set, g.set);
        check("rsp_way_at_hs", bus.alloc_rsp_way, g.way);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] s);
    check("req_ready_before_send", bus.alloc_req_ready, 1);
    bus.alloc_req_valid = 1'b1;
    bus.alloc_req_set   = s;
    tick();
    bus.alloc_req_valid = 1'b0;
  endtask

  task automatic wait_valid(input int budget);
    int n;
    n = 0;
    while (bus.alloc_rsp_valid !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check("grant_within_budget", bus.alloc_rsp_valid, 1);
  endtask

  task automatic accept();
    bus.alloc_rsp_ready = 1'b1;
    tick();
    bus.alloc_rsp_ready = 1'b0;
  endtask

  task automatic alloc(input logic [7:0] s, input logic [1:0] w);
    exp_q.push_back('{set: s, way: w});
    send(s);
    wait_valid(16);
    check("grant_set", bus.alloc_rsp_set, s);
    check("grant_way", bus.alloc_rsp_way, w);
    accept();
  endtask

  initial begin
    rst_n               = 1'b0;
    bus.alloc_req_valid = 1'b0;
    bus.alloc_req_set   = '0;
    bus.alloc_flush     = 1'b0;
    bus.way_pin_mask    = '0;
    bus.alloc_rsp_ready = 1'b0;
    cnt_tb              = '0;
    tick();
    tick();
    rst_n = 1'b1;

    // Reset state
    check("rst_req_ready", bus.alloc_req_ready, 1);
    check("rst_rsp_valid", bus.alloc_rsp_valid, 0);
    check("rst_access_valid", bus.ref_cnt_access_valid, 0);
    check("rst_stall_cnt", bus.alloc_stall_cnt, 0);
    check("rst_ref_cnt_set", bus.ref_cnt_set, 0);
    check("rst_rsp_set", bus.alloc_rsp_set, 0);
    check("rst_rsp_way", bus.alloc_rsp_way, 0);

    // Baseline: set 5, all free, pointer 0 -> way 0 at T+3
    exp_q.push_back('{set: 8'd5, way: 2'd0});
    send(8'd5);
    check("base_t1_ref_cnt_set", bus.ref_cnt_set, 5);
    check("base_t1_valid", bus.alloc_rsp_valid, 0);
    check("base_t1_ready", bus.alloc_req_ready, 0);
    tick();
    check("base_t2_valid", bus.alloc_rsp_valid, 0);
    check("base_t2_ref_cnt_set", bus.ref_cnt_set, 5);
    tick();
    check("base_t3_valid", bus.alloc_rsp_valid, 1);
    check("base_t3_set", bus.alloc_rsp_set, 5);
    check("base_t3_way", bus.alloc_rsp_way, 0);
    check("base_t3_ref_cnt_set", bus.ref_cnt_set, 5);
    p0 = pulse_cnt;
    accept();
    check("base_one_pulse", pulse_cnt, p0 + 1);
    check("base_ready_after_hs", bus.alloc_req_ready, 1);
    check("base_no_pulse_after", bus.ref_cnt_access_valid, 0);
    check("base_rr_ptr", dut.rr_ptr_q, 1);

    // Advance pointer to 2, then round-robin with ways 0,1 busy
    alloc(8'd7, 2'd1);
    cnt_tb[0] = 3'd1; cnt_tb[1] = 3'd1; cnt_tb[2] = 3'd0; cnt_tb[3] = 3'd0;
    alloc(8'd9, 2'd2);
    check("rr_ptr_after_way2", dut.rr_ptr_q, 3);

    // Wrap: pointer 3, way 3 busy -> way 0
    cnt_tb[0] = 3'd0; cnt_tb[1] = 3'd0; cnt_tb[2] = 3'd0; cnt_tb[3] = 3'd2;
    alloc(8'h11, 2'd0);
    check("rr_ptr_after_wrap", dut.rr_ptr_q, 1);

    // Pinning from pointer 0
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("pin_rr_ptr_reset", dut.rr_ptr_q, 0);
    cnt_tb = '0;
    bus.way_pin_mask = 4'b0001;
    alloc(8'h21, 2'd1);
    bus.way_pin_mask = 4'b0000;

    // Stall 10 EVAL cycles, then a credit frees way 3
    cnt_tb = {3'd1, 3'd1, 3'd1, 3'd1};
    exp_q.push_back('{set: 8'h30, way: 2'd3});
    send(8'h30);
    tick();
    repeat (10) tick();
    check("stall_cnt_10", bus.alloc_stall_cnt, 10);
    check("stall_no_grant", bus.alloc_rsp_valid, 0);
    cnt_tb[3] = 3'd0;
    tick();
    check("credit_x2_no_grant", bus.alloc_rsp_valid, 0);
    tick();
    check("credit_x3_grant", bus.alloc_rsp_valid, 1);
    check("credit_way", bus.alloc_rsp_way, 3);
    check("credit_set", bus.alloc_rsp_set, 8'h30);

    // Backpressure 5 cycles, with a flush in GRANT that must be ignored
    p0 = pulse_cnt;
    for (int i = 0; i < 5; i++) begin
      bus.alloc_flush = (i == 2);
      tick();
      bus.alloc_flush = 1'b0;
      check("bp_valid", bus.alloc_rsp_valid, 1);
      check("bp_set", bus.alloc_rsp_set, 8'h30);
      check("bp_way", bus.alloc_rsp_way, 3);
    end
    check("bp_no_pulse", pulse_cnt, p0);
    accept();
    check("bp_one_pulse", pulse_cnt, p0 + 1);
    check("bp_rr_ptr_wrapped", dut.rr_ptr_q, 0);

    // Saturation, then flush during the stall
    cnt_tb = {3'd1, 3'd1, 3'd1, 3'd1};
    send(8'h40);
    repeat (300) tick();
    check("stall_saturated", bus.alloc_stall_cnt, 255);
    check("sat_no_grant", bus.alloc_rsp_valid, 0);
    p0 = pulse_cnt;
    bus.alloc_flush = 1'b1;
    tick();
    bus.alloc_flush = 1'b0;
    check("flush_idle_ready", bus.alloc_req_ready, 1);
    check("flush_no_valid", bus.alloc_rsp_valid, 0);
    check("flush_rr_ptr", dut.rr_ptr_q, 0);
    check("flush_stall_held", bus.alloc_stall_cnt, 255);
    tick();
    check("flush_no_pulse", pulse_cnt, p0);
    check("flush_still_idle", bus.alloc_req_ready, 1);

    // Reset while a grant is pending
    cnt_tb = '0;
    send(8'h55);
    wait_valid(16);
    rst_n = 1'b0;
    tick();
    check("rstg_valid", bus.alloc_rsp_valid, 0);
    check("rstg_ready", bus.alloc_req_ready, 1);
    check("rstg_rsp_set", bus.alloc_rsp_set, 0);
    check("rstg_rsp_way", bus.alloc_rsp_way, 0);
    check("rstg_stall", bus.alloc_stall_cnt, 0);
    check("rstg_ref_cnt_set", bus.ref_cnt_set, 0);
    check("rstg_access", bus.ref_cnt_access_valid, 0);
    rst_n = 1'b1;

    // Normal operation resumes after reset
    alloc(8'h66, 2'd0);
    tick();
    check("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
